reset_sequencer: RTL



---
 rtl/reset_sequencer.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/reset_sequencer.sv
// Lock-gated staged reset release; optional lock-wait timeout flag
// enabled by defining RESET_SEQ_LOCK_TIMEOUT_EN.
module reset_sequencer #(
    parameter int NUM_STAGES          = 4,
    parameter int LOCK_STABLE_CYCLES  = 256,
    parameter int STAGE_GAP_CYCLES    = 64,
    parameter int LOCK_TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  pll_lock_i,
    output logic [NUM_STAGES-1:0] stage_rst_o,
    output logic                  done_o,
    output logic [7:0]            lock_loss_cnt_o,
    output logic                  lock_timeout_o
);

    typedef enum logic [1:0] {
        WAIT_LOCK,
        DEBOUNCE,
        RELEASE,
        DONE
    } state_t;

    localparam logic [31:0] STABLE_LAST = 32'(LOCK_STABLE_CYCLES - 1);
    localparam logic [31:0] GAP_LAST    = 32'(STAGE_GAP_CYCLES - 1);
    localparam logic [4:0]  IDX_LAST    = 5'(NUM_STAGES - 1);

    state_t                state_q, state_d;
    logic                  sync1_q, lock_s_q;
    logic [31:0]           stable_q, stable_d;
    logic [31:0]           gap_q, gap_d;
    logic [4:0]            idx_q, idx_d;
    logic [NUM_STAGES-1:0] stage_q, stage_d;
    logic                  done_q, done_d;
    logic [7:0]            loss_q, loss_d;
    logic [NUM_STAGES-1:0] rel_mask;

    assign rel_mask = NUM_STAGES'(1) << idx_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q  <= 1'b0;
            lock_s_q <= 1'b0;
            state_q  <= WAIT_LOCK;
            stable_q <= '0;
            gap_q    <= '0;
            idx_q    <= '0;
            stage_q  <= '1;
            done_q   <= 1'b0;
            loss_q   <= '0;
        end else begin
            sync1_q  <= pll_lock_i;
            lock_s_q <= sync1_q;
            state_q  <= state_d;
            stable_q <= stable_d;
            gap_q    <= gap_d;
            idx_q    <= idx_d;
            stage_q  <= stage_d;
            done_q   <= done_d;
            loss_q   <= loss_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        stable_d = stable_q;
        gap_d    = gap_q;
        idx_d    = idx_q;
        stage_d  = stage_q;
        done_d   = done_q;
        loss_d   = loss_q;
        unique case (state_q)
            WAIT_LOCK: begin
                stable_d = '0;
                if (lock_s_q) state_d = DEBOUNCE;
            end
            DEBOUNCE: begin
                if (!lock_s_q) begin
                    state_d  = WAIT_LOCK;
                    stable_d = '0;
                end else if (stable_q == STABLE_LAST) begin
                    state_d  = RELEASE;
                    stable_d = '0;
                    gap_d    = '0;
                    idx_d    = '0;
                end else begin
                    stable_d = stable_q + 32'd1;
                end
            end
            RELEASE, DONE: begin
                // Lock loss takes priority over a release due this edge
                if (!lock_s_q) begin
                    state_d  = WAIT_LOCK;
                    stage_d  = '1;
                    done_d   = 1'b0;
                    stable_d = '0;
                    gap_d    = '0;
                    idx_d    = '0;
                    if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
                end else if (state_q == RELEASE) begin
                    if (gap_q == GAP_LAST) begin
                        gap_d   = '0;
                        stage_d = stage_q & ~rel_mask;
                        idx_d   = idx_q + 5'd1;
                        if (idx_q == IDX_LAST) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        gap_d = gap_q + 32'd1;
                    end
                end
            end
            default: state_d = WAIT_LOCK;
        endcase
    end

`ifdef RESET_SEQ_LOCK_TIMEOUT_EN
    localparam logic [31:0] WAIT_LAST = 32'(LOCK_TIMEOUT_CYCLES - 1);

    logic [31:0] wait_q, wait_d;
    logic        tmo_q, tmo_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wait_q <= '0;
            tmo_q  <= 1'b0;
        end else begin
            wait_q <= wait_d;
            tmo_q  <= tmo_d;
        end
    end

    always_comb begin
        wait_d = '0;
        tmo_d  = tmo_q;
        if (state_q == WAIT_LOCK) begin
            if (wait_q == WAIT_LAST) begin
                tmo_d  = 1'b1;
                wait_d = wait_q;
            end else begin
                wait_d = wait_q + 32'd1;
            end
            if (state_d != WAIT_LOCK) wait_d = '0;
        end
    end

    assign lock_timeout_o = tmo_q;
`else
    assign lock_timeout_o = 1'b0;
`endif

    assign stage_rst_o     = stage_q;
    assign done_o          = done_q;
    assign lock_loss_cnt_o = loss_q;

endmodule
